// File: rtl/axis_bram_capture_ctrl.sv
// -----------------------------------------------------------------------------
// axis_bram_capture_ctrl
//
// Triggered acquisition controller. An AXI4-Stream sample stream is written
// into one BRAM write port as a circular buffer. The block keeps cfg_pre
// samples before the trigger and cfg_post samples after it. It then freezes
// the buffer and reports the trigger address, so software can unwrap the
// record.
//
// Ports:
//   aclk, aresetn         clock, synchronous active-low reset
//   run                   level enable; 0 aborts back to IDLE
//   trig                  trigger, honoured only in ARMED
//   cfg_pre, cfg_post     sample counts, latched when a capture starts
//   sts_addr              current write address
//   sts_trig_addr         write address latched on the trigger cycle
//   sts_state             registered state (IDLE=0 PRE=1 ARMED=2 POST=3 DONE=4)
//   done                  high while in DONE
//   s_axis_*              sample stream input (tready is registered from state)
//   bram_porta_*          BRAM write port (zero-latency write at sts_addr)
// -----------------------------------------------------------------------------
module axis_bram_capture_ctrl #(
    parameter int unsigned AXIS_TDATA_WIDTH = 32,
    parameter int unsigned BRAM_DATA_WIDTH  = 32,
    parameter int unsigned BRAM_ADDR_WIDTH  = 10
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic                           run,
    input  logic                           trig,
    input  logic [BRAM_ADDR_WIDTH-1:0]     cfg_pre,
    input  logic [BRAM_ADDR_WIDTH-1:0]     cfg_post,
    output logic [BRAM_ADDR_WIDTH-1:0]     sts_addr,
    output logic [BRAM_ADDR_WIDTH-1:0]     sts_trig_addr,
    output logic [2:0]                     sts_state,
    output logic                           done,
    output logic                           s_axis_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0]    s_axis_tdata,
    input  logic                           s_axis_tvalid,
    output logic                           bram_porta_clk,
    output logic                           bram_porta_rst,
    output logic [BRAM_ADDR_WIDTH-1:0]     bram_porta_addr,
    output logic [BRAM_DATA_WIDTH-1:0]     bram_porta_wrdata,
    output logic [BRAM_DATA_WIDTH/8-1:0]   bram_porta_we
);

    localparam int unsigned AW   = BRAM_ADDR_WIDTH;
    localparam int unsigned MinW = (AXIS_TDATA_WIDTH < BRAM_DATA_WIDTH) ?
                                   AXIS_TDATA_WIDTH : BRAM_DATA_WIDTH;
    localparam logic [AW-1:0] One = AW'(1);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StPre   = 3'd1,
        StArmed = 3'd2,
        StPost  = 3'd3,
        StDone  = 3'd4
    } state_e;

    state_e        r_state;
    state_e        w_state_next;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] r_trig_addr;
    logic [AW-1:0] r_pre_cnt;
    logic [AW-1:0] r_post_cnt;
    logic [AW-1:0] r_cfg_pre;
    logic [AW-1:0] r_cfg_post;
    logic          w_tready;
    logic          w_wr;
    logic          w_start;
    logic [AW:0]   w_pre_sum;
    logic [AW:0]   w_post_sum;

    assign w_wr    = s_axis_tvalid & w_tready;
    assign w_start = (r_state == StIdle) & run;

    // One extra bit so the count including this cycle's write cannot wrap.
    assign w_pre_sum  = {1'b0, r_pre_cnt}  + {{AW{1'b0}}, w_wr};
    assign w_post_sum = {1'b0, r_post_cnt} + {{AW{1'b0}}, w_wr};

    // State register
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a low run returns every active state to IDLE
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (run) w_state_next = StPre;
            end
            StPre: begin
                if (!run)                                w_state_next = StIdle;
                else if (w_pre_sum >= {1'b0, r_cfg_pre}) w_state_next = StArmed;
            end
            StArmed: begin
                if (!run)      w_state_next = StIdle;
                else if (trig) w_state_next = StPost;
            end
            StPost: begin
                if (!run)                                  w_state_next = StIdle;
                else if (w_post_sum == {1'b0, r_cfg_post}) w_state_next = StDone;
            end
            StDone: begin
                if (!run) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Outputs decoded from the registered state
    always_comb begin
        w_tready = 1'b0;
        done     = 1'b0;
        unique case (r_state)
            StPre, StArmed, StPost: w_tready = 1'b1;
            StDone:                 done     = 1'b1;
            default:                ;
        endcase
    end

    // Address, counters and latched configuration
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_addr      <= '0;
            r_trig_addr <= '0;
            r_pre_cnt   <= '0;
            r_post_cnt  <= '0;
            r_cfg_pre   <= '0;
            r_cfg_post  <= '0;
        end else if (w_start) begin
            r_addr     <= '0;
            r_pre_cnt  <= '0;
            r_post_cnt <= '0;
            r_cfg_pre  <= cfg_pre;
            r_cfg_post <= (cfg_post == '0) ? One : cfg_post;
        end else begin
            if (w_wr) r_addr <= r_addr + One;
            if (w_wr && r_state == StPre)  r_pre_cnt  <= r_pre_cnt + One;
            if (w_wr && r_state == StPost) r_post_cnt <= r_post_cnt + One;
            // Address before the increment: the trigger-cycle sample is pre-trigger
            if (r_state == StArmed && run && trig) r_trig_addr <= r_addr;
        end
    end

    assign s_axis_tready   = w_tready;
    assign sts_state       = r_state;
    assign sts_addr        = r_addr;
    assign sts_trig_addr   = r_trig_addr;
    assign bram_porta_clk  = aclk;
    assign bram_porta_rst  = ~aresetn;
    assign bram_porta_addr = r_addr;
    assign bram_porta_we   = {(BRAM_DATA_WIDTH/8){w_wr}};

    // Truncate or zero-extend the stream word to the BRAM width
    always_comb begin
        bram_porta_wrdata            = '0;
        bram_porta_wrdata[MinW-1:0]  = s_axis_tdata[MinW-1:0];
    end

endmodule

// File: tb/tb_axis_bram_capture_ctrl.sv
// -----------------------------------------------------------------------------
// tb_axis_bram_capture_ctrl
//
// Self-checking bench for axis_bram_capture_ctrl (AW=4, 32-bit stream into a
// 16-bit BRAM, so truncation is exercised). A capture reference model works in
// "samples still needed" terms and predicts every output each cycle. A short
// scripted capture is followed by a long randomized run with aborts and resets.
// -----------------------------------------------------------------------------
module tb_axis_bram_capture_ctrl;

    localparam int unsigned TW = 32;
    localparam int unsigned DW = 16;
    localparam int unsigned AW = 4;
    localparam int          Depth = 1 << AW;

    localparam int PhIdle  = 0;
    localparam int PhPre   = 1;
    localparam int PhArmed = 2;
    localparam int PhPost  = 3;
    localparam int PhDone  = 4;

    logic            aclk = 1'b0;
    logic            aresetn;
    logic            run;
    logic            trig;
    logic [AW-1:0]   cfg_pre;
    logic [AW-1:0]   cfg_post;
    logic [AW-1:0]   sts_addr;
    logic [AW-1:0]   sts_trig_addr;
    logic [2:0]      sts_state;
    logic            done;
    logic            s_axis_tready;
    logic [TW-1:0]   s_axis_tdata;
    logic            s_axis_tvalid;
    logic            bram_porta_clk;
    logic            bram_porta_rst;
    logic [AW-1:0]   bram_porta_addr;
    logic [DW-1:0]   bram_porta_wrdata;
    logic [DW/8-1:0] bram_porta_we;

    axis_bram_capture_ctrl #(
        .AXIS_TDATA_WIDTH (TW),
        .BRAM_DATA_WIDTH  (DW),
        .BRAM_ADDR_WIDTH  (AW)
    ) dut (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .run               (run),
        .trig              (trig),
        .cfg_pre           (cfg_pre),
        .cfg_post          (cfg_post),
        .sts_addr          (sts_addr),
        .sts_trig_addr     (sts_trig_addr),
        .sts_state         (sts_state),
        .done              (done),
        .s_axis_tready     (s_axis_tready),
        .s_axis_tdata      (s_axis_tdata),
        .s_axis_tvalid     (s_axis_tvalid),
        .bram_porta_clk    (bram_porta_clk),
        .bram_porta_rst    (bram_porta_rst),
        .bram_porta_addr   (bram_porta_addr),
        .bram_porta_wrdata (bram_porta_wrdata),
        .bram_porta_we     (bram_porta_we)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;

    // Reference model: capture phase plus remaining sample counts
    int m_phase     = PhIdle;
    int m_addr      = 0;
    int m_trig_addr = 0;
    int m_pre_left  = 0;
    int m_post_left = 0;

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        return (m_phase == PhPre) || (m_phase == PhArmed) || (m_phase == PhPost);
    endfunction

    // Advance the model by one clock edge using the currently driven inputs
    task automatic model_edge();
        bit wr;
        wr = s_axis_tvalid && model_ready();
        if (!aresetn) begin
            m_phase     = PhIdle;
            m_addr      = 0;
            m_trig_addr = 0;
            m_pre_left  = 0;
            m_post_left = 0;
            return;
        end
        if (m_phase == PhIdle) begin
            if (run) begin
                m_phase     = PhPre;
                m_addr      = 0;
                m_pre_left  = int'(cfg_pre);
                m_post_left = (cfg_post == 0) ? 1 : int'(cfg_post);
            end
            return;
        end
        if (m_phase == PhArmed && run && trig) m_trig_addr = m_addr;
        if (wr) m_addr = (m_addr + 1) % Depth;
        if (!run) begin
            m_phase = PhIdle;
            return;
        end
        case (m_phase)
            PhPre: begin
                if (wr) m_pre_left--;
                if (m_pre_left <= 0) m_phase = PhArmed;
            end
            PhArmed: if (trig) m_phase = PhPost;
            PhPost: begin
                if (wr) m_post_left--;
                if (m_post_left == 0) begin
                    m_phase = PhDone;
                    n_done++;
                end
            end
            default: ;
        endcase
    endtask

    // Compare all outputs for the inputs now driven, then take one clock edge
    task automatic step();
        bit wr;
        logic [DW-1:0] exp_data;
        #1;
        wr       = s_axis_tvalid && model_ready();
        exp_data = s_axis_tdata[DW-1:0];
        check_eq("tready",    s_axis_tready,   model_ready());
        check_eq("we",        bram_porta_we,   {(DW/8){wr}});
        check_eq("state",     sts_state,       m_phase);
        check_eq("done",      done,            m_phase == PhDone);
        check_eq("addr",      sts_addr,        m_addr);
        check_eq("bram_addr", bram_porta_addr, m_addr);
        check_eq("trig_addr", sts_trig_addr,   m_trig_addr);
        check_eq("bram_rst",  bram_porta_rst,  !aresetn);
        if (wr) check_eq("wrdata", bram_porta_wrdata, exp_data);
        model_edge();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        // Reset held with stream valid and run high
        aresetn       = 1'b0;
        run           = 1'b1;
        trig          = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'hdead_beef;
        cfg_pre       = 4'd3;
        cfg_post      = 4'd4;
        @(posedge aclk);
        #1;
        repeat (3) step();

        // Scripted capture: pre=3, post=4, trigger on the third ARMED cycle
        aresetn = 1'b1;
        step();                                   // IDLE -> PRE
        for (int i = 0; i < 3; i++) begin
            s_axis_tdata = $urandom;
            step();                               // PRE writes 0..2
        end
        for (int i = 0; i < 2; i++) begin
            s_axis_tdata = $urandom;
            step();                               // ARMED writes 3,4
        end
        trig = 1'b1;
        step();                                   // trigger cycle writes 5
        trig = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_axis_tdata = $urandom;
            step();                               // POST writes 6..9
        end
        check_eq("basic_trig_addr", sts_trig_addr, 5);
        check_eq("basic_end_addr",  sts_addr,      10);
        check_eq("basic_done",      done,          1'b1);
        check_eq("basic_we_off",    bram_porta_we, '0);
        repeat (3) step();
        run = 1'b0;
        step();

        // Randomized captures with aborts, restarts and rare resets
        for (int cyc = 0; cyc < 30000; cyc++) begin
            aresetn       = ($urandom_range(0, 1999) != 0);
            s_axis_tvalid = ($urandom_range(0, 2) != 0);
            s_axis_tdata  = $urandom;
            trig          = ($urandom_range(0, 24) == 0);
            cfg_pre       = AW'($urandom_range(0, Depth - 1));
            cfg_post      = ($urandom_range(0, 5) == 0) ? '0 : AW'($urandom_range(0, Depth - 1));
            if (m_phase == PhIdle || m_phase == PhDone) run = ($urandom_range(0, 3) != 0);
            else                                        run = ($urandom_range(0, 199) != 0);
            step();
        end
        check_eq("captures_completed", n_done > 20, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
